// File: rtl/bus_pkg.sv
// Shared types and default widths for the host/device bus arbiter slice.
package bus_pkg;

  localparam int NrHostsDef   = 2;
  localparam int NrDevicesDef = 3;
  localparam int AddrWidthDef = 32;
  localparam int DataWidthDef = 32;
  localparam int BeWidthDef   = DataWidthDef / 8;

  // Index width for a group of n agents; a single agent still gets one bit.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int HostSelWidth = sel_width(NrHostsDef);
  localparam int DevSelWidth  = sel_width(NrDevicesDef);

  typedef logic [HostSelWidth-1:0] host_sel_t;
  typedef logic [DevSelWidth-1:0]  dev_sel_t;

  typedef struct packed {
    logic                    we;
    logic [BeWidthDef-1:0]   be;
    logic [AddrWidthDef-1:0] addr;
    logic [DataWidthDef-1:0] wdata;
  } bus_req_t;

endpackage

// File: rtl/bus_addr_decode.sv
// Combinational base/mask address decoder; the lowest-index matching device wins.
module bus_addr_decode
  import bus_pkg::*;
#(
  parameter int NrDevices = NrDevicesDef,
  parameter int AddrWidth = AddrWidthDef,
  parameter int DevSelW   = sel_width(NrDevices)
) (
  input  logic [AddrWidth-1:0]           addr_i,
  input  logic [NrDevices*AddrWidth-1:0] base_i,
  input  logic [NrDevices*AddrWidth-1:0] mask_i,
  output logic [NrDevices-1:0]           match_o,
  output logic [DevSelW-1:0]             dev_sel_o,
  output logic                           unmapped_o
);

  // Scan from the top down so the lowest matching index is written last.
  always_comb begin
    match_o    = '0;
    dev_sel_o  = '0;
    unmapped_o = 1'b1;
    for (int d = NrDevices - 1; d >= 0; d--) begin
      if ((addr_i & mask_i[d*AddrWidth +: AddrWidth]) == base_i[d*AddrWidth +: AddrWidth]) begin
        match_o    = NrDevices'(1) << d;
        dev_sel_o  = DevSelW'(d);
        unmapped_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Host/device bus arbiter: one grant per cycle, response routed back one cycle later.
// Define BUS_RR_ARB_EN for round-robin arbitration; fixed priority (host 0 first) otherwise.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int NrHosts   = NrHostsDef,
  parameter int NrDevices = NrDevicesDef,
  parameter int AddrWidth = AddrWidthDef,
  parameter int DataWidth = DataWidthDef
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NrHosts-1:0]               host_req_i,
  output logic [NrHosts-1:0]               host_gnt_o,
  input  logic [NrHosts-1:0]               host_we_i,
  input  logic [NrHosts*(DataWidth/8)-1:0] host_be_i,
  input  logic [NrHosts*AddrWidth-1:0]     host_addr_i,
  input  logic [NrHosts*DataWidth-1:0]     host_wdata_i,
  output logic [NrHosts-1:0]               host_rvalid_o,
  output logic [NrHosts*DataWidth-1:0]     host_rdata_o,
  output logic [NrHosts-1:0]               host_err_o,
  output logic [NrDevices-1:0]             dev_req_o,
  output logic                             dev_we_o,
  output logic [DataWidth/8-1:0]           dev_be_o,
  output logic [AddrWidth-1:0]             dev_addr_o,
  output logic [DataWidth-1:0]             dev_wdata_o,
  input  logic [NrDevices-1:0]             dev_rvalid_i,
  input  logic [NrDevices*DataWidth-1:0]   dev_rdata_i,
  input  logic [NrDevices*AddrWidth-1:0]   cfg_dev_base_i,
  input  logic [NrDevices*AddrWidth-1:0]   cfg_dev_mask_i
);

  localparam int BeWidth  = DataWidth / 8;
  localparam int HostSelW = sel_width(NrHosts);
  localparam int DevSelW  = sel_width(NrDevices);

  logic [NrHosts-1:0]   req_act;
  logic                 gnt_valid;
  logic [HostSelW-1:0]  winner;
  logic                 mux_we;
  logic [BeWidth-1:0]   mux_be;
  logic [AddrWidth-1:0] mux_addr;
  logic [DataWidth-1:0] mux_wdata;
  logic [NrDevices-1:0] dec_match;
  logic [DevSelW-1:0]   dec_sel;
  logic                 dec_unmapped;

  logic                pend_q, pend_d;
  logic [HostSelW-1:0] host_sel_q, host_sel_d;
  logic [DevSelW-1:0]  dev_sel_q, dev_sel_d;
  logic                unmapped_q, unmapped_d;
`ifdef BUS_RR_ARB_EN
  logic [HostSelW-1:0] rr_ptr_q, rr_ptr_d;
`endif

  // Requests are masked in reset so every output reads zero while rst_ni is low.
  assign req_act   = host_req_i & {NrHosts{rst_ni}};
  assign gnt_valid = |req_act;

  // Search from the priority pointer upwards (modulo NrHosts); the first hit is written last.
  always_comb begin
    int start;
    int idx;
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    winner = '0;
    start  = 0;
`ifdef BUS_RR_ARB_EN
    start  = int'(rr_ptr_q);
`endif
    for (int i = NrHosts - 1; i >= 0; i--) begin
      idx = (start + i) % NrHosts;
      if (req_act[idx]) winner = HostSelW'(idx);
    end
  end

  always_comb begin
    mux_we    = 1'b0;
    mux_be    = '0;
    mux_addr  = '0;
    mux_wdata = '0;
    if (gnt_valid) begin
      mux_we    = host_we_i[winner];
      mux_be    = host_be_i[int'(winner)*BeWidth +: BeWidth];
      mux_addr  = host_addr_i[int'(winner)*AddrWidth +: AddrWidth];
      mux_wdata = host_wdata_i[int'(winner)*DataWidth +: DataWidth];
    end
  end

  bus_addr_decode #(
    .NrDevices(NrDevices),
    .AddrWidth(AddrWidth),
    .DevSelW  (DevSelW)
  ) u_decode (
    .addr_i    (mux_addr),
    .base_i    (cfg_dev_base_i),
    .mask_i    (cfg_dev_mask_i),
    .match_o   (dec_match),
    .dev_sel_o (dec_sel),
    .unmapped_o(dec_unmapped)
  );

  assign host_gnt_o  = gnt_valid ? (NrHosts'(1) << winner) : '0;
  assign dev_req_o   = gnt_valid ? dec_match : '0;
  assign dev_we_o    = mux_we;
  assign dev_be_o    = mux_be;
  assign dev_addr_o  = mux_addr;
  assign dev_wdata_o = mux_wdata;

  // Selects hold their value between grants; only pend_q tracks whether a response is due.
  always_comb begin
    pend_d     = gnt_valid;
    host_sel_d = host_sel_q;
    dev_sel_d  = dev_sel_q;
    unmapped_d = unmapped_q;
    if (gnt_valid) begin
      host_sel_d = winner;
      dev_sel_d  = dec_sel;
      unmapped_d = dec_unmapped;
    end
  end

`ifdef BUS_RR_ARB_EN
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (gnt_valid) rr_ptr_d = (int'(winner) == NrHosts - 1) ? '0 : winner + HostSelW'(1);
  end
`endif

  // NOTE: sequential state uses non-blocking assignments and an asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q     <= 1'b0;
      host_sel_q <= '0;
      dev_sel_q  <= '0;
      unmapped_q <= 1'b0;
`ifdef BUS_RR_ARB_EN
      rr_ptr_q   <= '0;
`endif
    end else begin
      pend_q     <= pend_d;
      host_sel_q <= host_sel_d;
      dev_sel_q  <= dev_sel_d;
      unmapped_q <= unmapped_d;
`ifdef BUS_RR_ARB_EN
      rr_ptr_q   <= rr_ptr_d;
`endif
    end
  end

  // Unmapped accesses answer with an error on their own; mapped ones forward the device reply.
  always_comb begin
    host_rvalid_o = '0;
    host_err_o    = '0;
    host_rdata_o  = '0;
    if (pend_q) begin
      if (unmapped_q) begin
        host_rvalid_o[host_sel_q] = 1'b1;
        host_err_o[host_sel_q]    = 1'b1;
      end else begin
        host_rvalid_o[host_sel_q] = dev_rvalid_i[dev_sel_q];
        host_rdata_o[int'(host_sel_q)*DataWidth +: DataWidth] =
            dev_rdata_i[int'(dev_sel_q)*DataWidth +: DataWidth];
      end
    end
  end

endmodule
